// File: rtl/dl_wrbuf_pkg.sv
// Shared types and default sizing for the download write buffer.
// The optional overflow flag is enabled by defining DL_WRBUF_OVF_EN.
package dl_wrbuf_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_AW    = 25;
  localparam int DEFAULT_DW    = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

endpackage

// File: rtl/dl_wrbuf_fifo.sv
// Synchronous FIFO backing the download write buffer; head is presented combinationally.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module dl_fifo #(
  parameter  int DEPTH = 8,
  parameter  int W     = 33,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [LW-1:0] level
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (level != '0);
  assign do_push = push && ((level != FULL_LVL) || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dl_wrbuf.sv
// Download write buffer: queues download writes and replays them as memory requests.
// Define DL_WRBUF_OVF_EN to add the sticky ovf output for dropped writes.
module dl_wrbuf
  import dl_wrbuf_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  parameter  int AW    = DEFAULT_AW,
  parameter  int DW    = DEFAULT_DW,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_a,
  input  logic [DW-1:0] dl_d,
  input  logic          downloading,
  input  logic          cpu_busy,
  output logic          mem_req,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  input  logic          mem_ack,
  output logic [LW-1:0] level,
  output logic          busy
`ifdef DL_WRBUF_OVF_EN
  ,
  output logic          ovf
`endif
);

  state_e             state;
  logic               pop;
  logic [AW+DW-1:0]   head;

  assign pop = (state == REQ) && mem_ack;

  dl_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (dl_wr),
    .pop     (pop),
    .wdata   ({dl_a, dl_d}),
    .rdata   (head),
    .level   (level)
  );

  // The request registers are loaded once on entry to REQ and then frozen until ack,
  // so cpu_busy can block a new request but never withdraw one in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      mem_req <= 1'b0;
      mem_a   <= '0;
      mem_d   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((level != '0) && !cpu_busy) begin
            state          <= REQ;
            mem_req        <= 1'b1;
            {mem_a, mem_d} <= head;
          end
        end
        REQ: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign busy = downloading || (level != '0) || mem_req;

`ifdef DL_WRBUF_OVF_EN
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic downloading_q;
  logic drop;

  assign drop = dl_wr && (level == FULL_LVL) && !pop;

  // A new download session clears the flag, taking priority over a same-cycle drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      downloading_q <= 1'b0;
      ovf           <= 1'b0;
    end else begin
      downloading_q <= downloading;
      if (downloading && !downloading_q) ovf <= 1'b0;
      else if (drop)                     ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dl_wrbuf.sv
// Directed self-checking bench for dl_wrbuf with a queue scoreboard of expected requests.
// Overflow checks are compiled in when DL_WRBUF_OVF_EN is defined.
module tb_dl_wrbuf;

  localparam int DEPTH = 8;
  localparam int AW    = 25;
  localparam int DW    = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } entry_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          dl_wr;
  logic [AW-1:0] dl_a;
  logic [DW-1:0] dl_d;
  logic          downloading;
  logic          cpu_busy;
  logic          mem_req;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic          mem_ack;
  logic [LW-1:0] level;
  logic          busy;
`ifdef DL_WRBUF_OVF_EN
  logic          ovf;
`endif

  int     checks = 0;
  int     errors = 0;
  int     model_level = 0;
  entry_t sb[$];

  always #5 clk = ~clk;

  dl_wrbuf #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .dl_wr       (dl_wr),
    .dl_a        (dl_a),
    .dl_d        (dl_d),
    .downloading (downloading),
    .cpu_busy    (cpu_busy),
    .mem_req     (mem_req),
    .mem_a       (mem_a),
    .mem_d       (mem_d),
    .mem_ack     (mem_ack),
    .level       (level),
    .busy        (busy)
`ifdef DL_WRBUF_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One write per call; the model decides acceptance assuming no concurrent pop.
  task automatic apply_stimulus(input logic [AW-1:0] a, input logic [DW-1:0] d);
    entry_t e;
    dl_wr = 1'b1;
    dl_a  = a;
    dl_d  = d;
    if (model_level < DEPTH) begin
      e.a = a;
      e.d = d;
      sb.push_back(e);
      model_level++;
    end
    @(negedge clk);
    dl_wr = 1'b0;
  endtask

  // Wait (bounded) for a request, compare it to the scoreboard head, hold, then ack it.
  task automatic serve(input string tag, input int hold);
    entry_t e;
    int     n;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_req"}, 32'(mem_req), 32'd1);
    if (sb.size() == 0) begin
      check_output({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    if (mem_req !== 1'b1) begin
      model_level--;
      return;
    end
    check_output({tag, "_a"}, 32'(mem_a), 32'(e.a));
    check_output({tag, "_d"}, 32'(mem_d), 32'(e.d));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_output({tag, "_hold_req"}, 32'(mem_req), 32'd1);
      check_output({tag, "_hold_a"}, 32'(mem_a), 32'(e.a));
      check_output({tag, "_hold_d"}, 32'(mem_d), 32'(e.d));
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    model_level--;
    check_output({tag, "_req_clr"}, 32'(mem_req), 32'd0);
    check_output({tag, "_level"}, 32'(level), 32'(model_level));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    entry_t e;
    reset_n     = 1'b0;
    dl_wr       = 1'b0;
    dl_a        = '0;
    dl_d        = '0;
    downloading = 1'b0;
    cpu_busy    = 1'b0;
    mem_ack     = 1'b0;

    // Reset state
    @(negedge clk);
    check_output("rst_req", 32'(mem_req), 32'd0);
    check_output("rst_level", 32'(level), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_a", 32'(mem_a), 32'd0);
    check_output("rst_d", 32'(mem_d), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    downloading = 1'b1;
    @(negedge clk);

    // Single write, latency of one edge after capture, ack after 3 held cycles
    apply_stimulus(25'h040000, 8'hA5);
    check_output("single_level", 32'(level), 32'd1);
    check_output("single_latency0", 32'(mem_req), 32'd0);
    @(negedge clk);
    check_output("single_latency1", 32'(mem_req), 32'd1);
    serve("single", 3);

    // Burst of 8 fills the FIFO, 9th is dropped, then drains in order
    for (int i = 0; i < DEPTH; i++) apply_stimulus(25'h200000 + 25'(i), 8'h10 + 8'(i));
    check_output("burst_level", 32'(level), 32'd8);
    apply_stimulus(25'h200008, 8'hEE);
    check_output("burst_drop_level", 32'(level), 32'd8);
`ifdef DL_WRBUF_OVF_EN
    check_output("burst_ovf", 32'(ovf), 32'd1);
`endif
    for (int i = 0; i < DEPTH; i++) serve("burst", 0);
    check_output("burst_empty", 32'(level), 32'd0);

    // New download session, then full FIFO with a write coincident with an ack
    downloading = 1'b0;
    @(negedge clk);
    downloading = 1'b1;
    @(negedge clk);
`ifdef DL_WRBUF_OVF_EN
    check_output("ovf_cleared", 32'(ovf), 32'd0);
`endif
    for (int i = 0; i < DEPTH; i++) apply_stimulus(25'h300000 + 25'(i), 8'h30 + 8'(i));
    check_output("full_level", 32'(level), 32'd8);
    check_output("full_req", 32'(mem_req), 32'd1);
    e = sb.pop_front();
    check_output("full_head_a", 32'(mem_a), 32'(e.a));
    e.a = 25'h300008;
    e.d = 8'h38;
    sb.push_back(e);
    dl_wr   = 1'b1;
    dl_a    = 25'h300008;
    dl_d    = 8'h38;
    mem_ack = 1'b1;
    @(negedge clk);
    dl_wr   = 1'b0;
    mem_ack = 1'b0;
    check_output("simul_level", 32'(level), 32'd8);
    check_output("simul_req_clr", 32'(mem_req), 32'd0);
`ifdef DL_WRBUF_OVF_EN
    check_output("simul_ovf", 32'(ovf), 32'd0);
`endif
    for (int i = 0; i < DEPTH; i++) serve("simul", 0);

    // cpu_busy blocks a new request but cannot withdraw one in flight
    cpu_busy = 1'b1;
    apply_stimulus(25'h0ABCDE, 8'h3C);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("cpubusy_block", 32'(mem_req), 32'd0);
    end
    check_output("cpubusy_level", 32'(level), 32'd1);
    cpu_busy = 1'b0;
    @(negedge clk);
    check_output("cpubusy_start", 32'(mem_req), 32'd1);
    cpu_busy = 1'b1;
    serve("cpubusy_hold", 4);
    cpu_busy = 1'b0;

    // Asynchronous reset in the middle of a request
    for (int i = 0; i < 3; i++) apply_stimulus(25'h400000 + 25'(i), 8'h40 + 8'(i));
    check_output("midrst_pre_level", 32'(level), 32'd3);
    check_output("midrst_pre_req", 32'(mem_req), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("midrst_req", 32'(mem_req), 32'd0);
    check_output("midrst_level", 32'(level), 32'd0);
    check_output("midrst_a", 32'(mem_a), 32'd0);
    sb.delete();
    model_level = 0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("midrst_quiet", 32'(mem_req), 32'd0);
    end

    // Spurious ack in IDLE must not pop
    cpu_busy = 1'b1;
    apply_stimulus(25'h500000, 8'h5A);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check_output("spurious_level", 32'(level), 32'd1);
    check_output("spurious_req", 32'(mem_req), 32'd0);
    cpu_busy = 1'b0;
    serve("spurious_drain", 1);

    // busy stays high after download ends until the last request completes
    cpu_busy = 1'b1;
    apply_stimulus(25'h600000, 8'h61);
    apply_stimulus(25'h600001, 8'h62);
    downloading = 1'b0;
    @(negedge clk);
    check_output("busy_lvl2", 32'(busy), 32'd1);
    check_output("busy_level", 32'(level), 32'd2);
    cpu_busy = 1'b0;
    serve("busy_first", 0);
    check_output("busy_after_first", 32'(busy), 32'd1);
    serve("busy_second", 0);
    check_output("busy_after_second", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
